// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS-32 instruction fetch stage: PC, imem req/ack, IF/ID register, redirects and stalls
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [5:0]  opcode,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] addr_plus4;
    logic        unused_target_bits;

    assign unused_target_bits = ^branch_target[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;

        // The branch is older than the jump sitting in ID, so it takes priority.
        redirect   = branch_taken | jump;
        target     = branch_taken ? {branch_target[31:2], 2'b00}
                                  : {pc4_q[31:28], instr_q[25:0], 2'b00};
        addr_plus4 = addr_q + 32'd4;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = redirect ? target : pc_q;
                if (redirect) pc_d = target;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d   = target;
                        addr_d = target;
                    end else if (!stall) begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        pc4_d   = addr_plus4;
                        pc_d    = addr_plus4;
                        addr_d  = addr_plus4;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = addr_plus4;
                        pc_d         = addr_plus4;
                        req_d        = 1'b0;
                        state_d      = S_HOLD;
                    end
                end else if (redirect) begin
                    // The outstanding read cannot be cancelled; wait it out and drop it.
                    pc_d    = target;
                    state_d = S_DISCARD;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    addr_d  = target;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    instr_d = hold_instr_q;
                    pc4_d   = hold_pc4_q;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (redirect) pc_d = target;
                if (imem_ack) begin
                    addr_d  = redirect ? target : pc_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
                req_d   = 1'b0;
            end
        endcase

        if (redirect) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC_ALIGNED;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC_ALIGNED;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'h0000_0000;
            hold_instr_q <= NOP_INSTR;
            hold_pc4_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign opcode         = instr_q[31:26];
    assign pc             = pc_q;

endmodule
